// File: rtl/dp_exec_ctrl.sv
// dp_exec_ctrl: initiator side of the 32-bit ALU for ARM data-processing ops.
// Takes one decoded request, drives the ALU, evaluates the condition field
// against the NZCV register, and issues a single register-file writeback.
// Optional build macro: DP_PERF_CNT_EN adds the exec_cnt/skip_cnt counters.
module dp_exec_ctrl #(
  parameter int unsigned REG_AW   = 4,
  parameter logic [3:0]  NZCV_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_opcode,
  input  logic [3:0]        req_cond,
  input  logic              req_s,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [31:0]       req_a,
  input  logic [31:0]       req_b,
  input  logic              req_sco,
  output logic [3:0]        alu_op,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic              alu_sco,
  output logic              alu_cf,
  output logic              alu_vf,
  input  logic [31:0]       alu_f,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic [3:0]        nzcv,
  output logic              done,
  output logic              skipped,
`ifdef DP_PERF_CNT_EN
  output logic [31:0]       exec_cnt,
  output logic [31:0]       skip_cnt,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e              state_q, state_d;
  logic [3:0]          opcode_q, cond_q, op_q;
  logic                s_q, sco_q;
  logic [REG_AW-1:0]   rd_q;
  logic [31:0]         a_q, b_q;
  logic [3:0]          nzcv_q;
  logic                rf_we_q, done_q, skipped_q;
  logic [REG_AW-1:0]   rf_waddr_q;
  logic [31:0]         rf_wdata_q;
  logic                accept, test_cls, cond_pass;

  // TST/TEQ/CMP/CMN share the AND/EOR/SUB/ADD datapath; everything else is 1:1.
  function automatic logic [3:0] map_op(input logic [3:0] opc);
    case (opc)
      4'b1000: map_op = 4'b0000;
      4'b1001: map_op = 4'b0001;
      4'b1010: map_op = 4'b0010;
      4'b1011: map_op = 4'b0100;
      default: map_op = opc;
    endcase
  endfunction

  // ARM condition codes against flags {N,Z,C,V}.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    cond_ok = z;
      4'h1:    cond_ok = !z;
      4'h2:    cond_ok = cf;
      4'h3:    cond_ok = !cf;
      4'h4:    cond_ok = n;
      4'h5:    cond_ok = !n;
      4'h6:    cond_ok = v;
      4'h7:    cond_ok = !v;
      4'h8:    cond_ok = cf & !z;
      4'h9:    cond_ok = !cf | z;
      4'hA:    cond_ok = (n == v);
      4'hB:    cond_ok = (n != v);
      4'hC:    cond_ok = !z & (n == v);
      4'hD:    cond_ok = z | (n != v);
      4'hE:    cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  endfunction

  assign accept    = req_valid && (state_q == StIdle);
  assign test_cls  = (opcode_q[3:2] == 2'b10);
  assign cond_pass = cond_ok(cond_q, nzcv_q);

  // Next-state logic: fixed three-step sequence, no early exits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_valid) state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Request capture on accept; fields feed the ALU during EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= '0;
      cond_q   <= '0;
      op_q     <= '0;
      s_q      <= 1'b0;
      sco_q    <= 1'b0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else if (accept) begin
      opcode_q <= req_opcode;
      cond_q   <= req_cond;
      op_q     <= map_op(req_opcode);
      s_q      <= req_s;
      sco_q    <= req_sco;
      rd_q     <= req_rd;
      a_q      <= req_a;
      b_q      <= req_b;
    end
  end

  // End of EXEC: capture ALU result and flags so they are visible during WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      nzcv_q     <= NZCV_RST;
      rf_we_q    <= 1'b0;
      done_q     <= 1'b0;
      skipped_q  <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q   <= 1'b0;
      done_q    <= 1'b0;
      skipped_q <= 1'b0;
      if (state_q == StExec) begin
        done_q <= 1'b1;
        if (cond_pass) begin
          if (!test_cls) begin
            rf_we_q    <= 1'b1;
            rf_waddr_q <= rd_q;
            rf_wdata_q <= alu_f;
          end
          if (s_q || test_cls) nzcv_q <= {alu_n, alu_z, alu_c, alu_v};
        end else begin
          skipped_q <= 1'b1;
        end
      end
    end
  end

`ifdef DP_PERF_CNT_EN
  logic [31:0] exec_cnt_q, skip_cnt_q;

  // Completion counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      exec_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else if (done_q) begin
      if (skipped_q) skip_cnt_q <= skip_cnt_q + 32'd1;
      else           exec_cnt_q <= exec_cnt_q + 32'd1;
    end
  end

  assign exec_cnt = exec_cnt_q;
  assign skip_cnt = skip_cnt_q;
`endif

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sco   = sco_q;
  assign alu_cf    = nzcv_q[1];
  assign alu_vf    = nzcv_q[0];
  assign nzcv      = nzcv_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign done      = done_q;
  assign skipped   = skipped_q;

endmodule
